// File: rtl/complex_dual_arith_pkg.sv
// Shared constants and the width-generic round/saturate helper for complex_dual_arith.
// The helper works on a 64-bit signed container, so WIDTH may be at most 31.
package complex_dual_arith_pkg;

    localparam logic MODE_ADDSUB = 1'b0;
    localparam logic MODE_MULT   = 1'b1;

    // shift > 0 adds half an LSB first (round half up). sat clips to w bits; otherwise the low w bits wrap.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] x,
        input int                 shift,
        input int                 w,
        input bit                 sat
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v = x;
        if (shift > 0) begin
            v = v + (64'sd1 <<< (shift - 1));
        end
        v  = v >>> shift;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (sat) begin
            if (v > hi) begin
                v = hi;
            end else if (v < lo) begin
                v = lo;
            end
        end else begin
            v = (v <<< (64 - w)) >>> (64 - w);
        end
        return v;
    endfunction

endpackage

// File: rtl/complex_dual_arith_if.sv
// AXI-Stream link carrying one complex sample: I in the upper half of tdata, Q in the lower half.
interface complex_dual_arith_if #(
    parameter int WIDTH = 16
) ();

    logic [2*WIDTH-1:0] tdata;
    logic               tlast;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axi_fifo.sv
// Synchronous AXI-Stream FIFO of depth 2**SIZE that stores tdata together with tlast.
// enq.tready is the plain not-full flag; a write into a full FIFO is still taken when a read happens in the same cycle.
module axi_fifo #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 5
) (
    input logic clk,
    input logic reset_n,
    complex_dual_arith_if.slave  enq,
    complex_dual_arith_if.master deq
);

    localparam int DW    = 2*WIDTH + 1;
    localparam int DEPTH = 2**SIZE;

    logic [DW-1:0]   mem [DEPTH];
    logic [SIZE-1:0] wr_ptr;
    logic [SIZE-1:0] rd_ptr;
    logic [SIZE:0]   count;
    logic            full;
    logic            empty;
    logic            wr;
    logic            rd;

    assign full  = (count == DEPTH[SIZE:0]);
    assign empty = (count == '0);
    assign rd    = deq.tready & ~empty;
    assign wr    = enq.tvalid & (~full | rd);

    assign enq.tready               = ~full;
    assign deq.tvalid               = ~empty;
    assign {deq.tlast, deq.tdata}   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + SIZE'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + SIZE'(1);
            end
            case ({wr, rd})
                2'b10:   count <= count + (SIZE+1)'(1);
                2'b01:   count <= count - (SIZE+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= {enq.tlast, enq.tdata};
        end
    end

endmodule

// File: rtl/cplx_round_sat.sv
// Stage-3 scaling of one real or imaginary component down to WIDTH bits.
// ADDSUB values pass unshifted; MULT products drop WIDTH-1 fraction bits.
module cplx_round_sat
    import complex_dual_arith_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 1
) (
    input  logic                    mode,
    input  logic signed [2*WIDTH:0] value,
    output logic signed [WIDTH-1:0] result
);

    assign result = WIDTH'(round_sat(64'(value),
                                     (mode == MODE_MULT) ? WIDTH - 1 : 0,
                                     WIDTH,
                                     SATURATE != 0));

endmodule

// File: rtl/complex_dual_arith.sv
// Joins two complex streams beat-for-beat and produces sum/difference or a*b / a*conj(b)
// through a 3-stage pipeline into two independently drained output FIFOs.
module complex_dual_arith
    import complex_dual_arith_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FIFO_SIZE = 5,
    parameter int SATURATE  = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mode,
    complex_dual_arith_if.slave  i0,
    complex_dual_arith_if.slave  i1,
    complex_dual_arith_if.master o0,
    complex_dual_arith_if.master o1,
    output logic tlast_err
);

    localparam int SW = 2*WIDTH + 1;

    complex_dual_arith_if #(.WIDTH(WIDTH)) fifo_in0 ();
    complex_dual_arith_if #(.WIDTH(WIDTH)) fifo_in1 ();

    logic pipe_en;
    logic accept;
    logic sop;
    logic mode_lat;
    logic cur_mode;
    logic vld_p0;
    logic vld_p1;
    logic vld_p2;

    logic signed [WIDTH-1:0] ar_p0, ai_p0, br_p0, bi_p0;
    logic                    mode_p0, mode_p1;
    logic                    tlast_p0, tlast_p1, tlast_p2;

    logic signed [2*WIDTH-1:0] pr_rr, pr_ii, pr_ri, pr_ir;
    logic signed [SW-1:0]      s0_re_c, s0_im_c, s1_re_c, s1_im_c;
    logic signed [SW-1:0]      s0_re_p1, s0_im_p1, s1_re_p1, s1_im_p1;

    logic signed [WIDTH-1:0] r0_re_c, r0_im_c, r1_re_c, r1_im_c;
    logic signed [WIDTH-1:0] r0_re_p2, r0_im_p2, r1_re_p2, r1_im_p2;

    // Stage 3 holds its result until both FIFOs can take it; everything upstream waits with it.
    assign pipe_en  = ~(vld_p2 & (~fifo_in0.tready | ~fifo_in1.tready));
    assign accept   = reset_n & i0.tvalid & i1.tvalid & pipe_en;
    assign cur_mode = sop ? mode : mode_lat;

    assign i0.tready = accept;
    assign i1.tready = accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            sop       <= 1'b1;
            mode_lat  <= MODE_ADDSUB;
            tlast_err <= 1'b0;
        end else begin
            if (pipe_en) begin
                vld_p0 <= accept;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1;
            end
            if (accept) begin
                sop <= i0.tlast;
                if (sop) begin
                    mode_lat <= mode;
                end
                if (i0.tlast != i1.tlast) begin
                    tlast_err <= 1'b1;
                end
            end
        end
    end

    // Stage 1: register the joined operands with the packet's mode and tlast
    always_ff @(posedge clk) begin
        if (pipe_en) begin
            ar_p0    <= $signed(i0.tdata[2*WIDTH-1:WIDTH]);
            ai_p0    <= $signed(i0.tdata[WIDTH-1:0]);
            br_p0    <= $signed(i1.tdata[2*WIDTH-1:WIDTH]);
            bi_p0    <= $signed(i1.tdata[WIDTH-1:0]);
            mode_p0  <= cur_mode;
            tlast_p0 <= i0.tlast;
        end
    end

    // Stage 2: full-precision sums or products, no rounding yet
    always_comb begin
        pr_rr = (2*WIDTH)'(ar_p0) * (2*WIDTH)'(br_p0);
        pr_ii = (2*WIDTH)'(ai_p0) * (2*WIDTH)'(bi_p0);
        pr_ri = (2*WIDTH)'(ar_p0) * (2*WIDTH)'(bi_p0);
        pr_ir = (2*WIDTH)'(ai_p0) * (2*WIDTH)'(br_p0);
        if (mode_p0 == MODE_MULT) begin
            s0_re_c = SW'(pr_rr) - SW'(pr_ii);
            s0_im_c = SW'(pr_ri) + SW'(pr_ir);
            s1_re_c = SW'(pr_rr) + SW'(pr_ii);
            s1_im_c = SW'(pr_ir) - SW'(pr_ri);
        end else begin
            s0_re_c = SW'(ar_p0) + SW'(br_p0);
            s0_im_c = SW'(ai_p0) + SW'(bi_p0);
            s1_re_c = SW'(ar_p0) - SW'(br_p0);
            s1_im_c = SW'(ai_p0) - SW'(bi_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (pipe_en) begin
            s0_re_p1 <= s0_re_c;
            s0_im_p1 <= s0_im_c;
            s1_re_p1 <= s1_re_c;
            s1_im_p1 <= s1_im_c;
            mode_p1  <= mode_p0;
            tlast_p1 <= tlast_p0;
        end
    end

    // Stage 3: scale each component back to WIDTH bits
    cplx_round_sat #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_rs0_re (
        .mode(mode_p1), .value(s0_re_p1), .result(r0_re_c));
    cplx_round_sat #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_rs0_im (
        .mode(mode_p1), .value(s0_im_p1), .result(r0_im_c));
    cplx_round_sat #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_rs1_re (
        .mode(mode_p1), .value(s1_re_p1), .result(r1_re_c));
    cplx_round_sat #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_rs1_im (
        .mode(mode_p1), .value(s1_im_p1), .result(r1_im_c));

    always_ff @(posedge clk) begin
        if (pipe_en) begin
            r0_re_p2 <= r0_re_c;
            r0_im_p2 <= r0_im_c;
            r1_re_p2 <= r1_re_c;
            r1_im_p2 <= r1_im_c;
            tlast_p2 <= tlast_p1;
        end
    end

    // Output FIFOs: both are written together so o0 and o1 stay beat-aligned
    assign fifo_in0.tdata  = {r0_re_p2, r0_im_p2};
    assign fifo_in0.tlast  = tlast_p2;
    assign fifo_in0.tvalid = vld_p2 & pipe_en;
    assign fifo_in1.tdata  = {r1_re_p2, r1_im_p2};
    assign fifo_in1.tlast  = tlast_p2;
    assign fifo_in1.tvalid = vld_p2 & pipe_en;

    axi_fifo #(.WIDTH(WIDTH), .SIZE(FIFO_SIZE)) u_fifo0 (
        .clk(clk), .reset_n(reset_n), .enq(fifo_in0), .deq(o0));
    axi_fifo #(.WIDTH(WIDTH), .SIZE(FIFO_SIZE)) u_fifo1 (
        .clk(clk), .reset_n(reset_n), .enq(fifo_in1), .deq(o1));

endmodule

// File: tb/tb_complex_dual_arith.sv
// Scoreboard bench for complex_dual_arith: directed vectors push expected results,
// a negedge monitor pops and compares whenever an output beat is transferred.
module tb_complex_dual_arith;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mode_s = 1'b0;
    logic tlast_err;
    logic tlast_err_w;

    always #5 clk = ~clk;

    complex_dual_arith_if #(.WIDTH(W)) i0 ();
    complex_dual_arith_if #(.WIDTH(W)) i1 ();
    complex_dual_arith_if #(.WIDTH(W)) o0 ();
    complex_dual_arith_if #(.WIDTH(W)) o1 ();
    complex_dual_arith_if #(.WIDTH(W)) wi0 ();
    complex_dual_arith_if #(.WIDTH(W)) wi1 ();
    complex_dual_arith_if #(.WIDTH(W)) wo0 ();
    complex_dual_arith_if #(.WIDTH(W)) wo1 ();

    complex_dual_arith #(.WIDTH(W), .FIFO_SIZE(2), .SATURATE(1)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode_s),
        .i0(i0), .i1(i1), .o0(o0), .o1(o1), .tlast_err(tlast_err));

    complex_dual_arith #(.WIDTH(W), .FIFO_SIZE(1), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .mode(1'b0),
        .i0(wi0), .i1(wi1), .o0(wo0), .o1(wo1), .tlast_err(tlast_err_w));

    int checks = 0;
    int errors = 0;
    int o0_cnt = 0;
    int o1_cnt = 0;
    int acc_cnt = 0;
    logic [32:0] exp0[$];
    logic [32:0] exp1[$];

    function automatic logic [32:0] ev(input logic last, input logic [15:0] re, input logic [15:0] im);
        return {last, re, im};
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && o0.tvalid && o0.tready) begin
            o0_cnt++;
            if (exp0.size() == 0) begin
                checks++; errors++;
                $display("FAIL o0_extra: got %h, expected no beat", {o0.tlast, o0.tdata});
            end else begin
                chk("o0_beat", {o0.tlast, o0.tdata}, exp0.pop_front());
            end
        end
        if (reset_n && o1.tvalid && o1.tready) begin
            o1_cnt++;
            if (exp1.size() == 0) begin
                checks++; errors++;
                $display("FAIL o1_extra: got %h, expected no beat", {o1.tlast, o1.tdata});
            end else begin
                chk("o1_beat", {o1.tlast, o1.tdata}, exp1.pop_front());
            end
        end
        if (reset_n && i0.tvalid && i0.tready) acc_cnt++;
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m,
                        input logic l0, input logic l1, input logic [32:0] e0, input logic [32:0] e1);
        int n;
        logic hs;
        i0.tdata = a; i1.tdata = b; mode_s = m;
        i0.tlast = l0; i1.tlast = l1;
        i0.tvalid = 1'b1; i1.tvalid = 1'b1;
        exp0.push_back(e0);
        exp1.push_back(e1);
        n = 0; hs = 1'b0;
        while (!hs && n < 300) begin
            @(negedge clk);
            hs = i0.tready;
            @(posedge clk);
            n++;
        end
        #1;
        i0.tvalid = 1'b0; i1.tvalid = 1'b0;
        if (!hs) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no tready, expected handshake within 300 clks");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 33'(exp0.size() + exp1.size()), 33'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end before 500us");
        $fatal(1);
    end

    initial begin
        int b0;
        int b1;
        int ba;
        int n;
        logic hs;
        i0.tdata = 32'h1234_5678; i1.tdata = 32'h1111_2222;
        i0.tlast = 1'b0; i1.tlast = 1'b0;
        i0.tvalid = 1'b1; i1.tvalid = 1'b1;
        o0.tready = 1'b0; o1.tready = 1'b0;
        wi0.tdata = '0; wi1.tdata = '0; wi0.tlast = 1'b0; wi1.tlast = 1'b0;
        wi0.tvalid = 1'b0; wi1.tvalid = 1'b0;
        wo0.tready = 1'b1; wo1.tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o0_tvalid", 33'(o0.tvalid), 33'd0);
        chk("rst_o1_tvalid", 33'(o1.tvalid), 33'd0);
        chk("rst_i0_tready", 33'(i0.tready), 33'd0);
        chk("rst_i1_tready", 33'(i1.tready), 33'd0);
        chk("rst_tlast_err", 33'(tlast_err), 33'd0);
        @(posedge clk); #1;
        i0.tvalid = 1'b0; i1.tvalid = 1'b0;
        reset_n = 1'b1;
        o0.tready = 1'b1; o1.tready = 1'b1;
        repeat (2) @(posedge clk); #1;

        // ADDSUB basic with latency check
        send(32'h1000_2000, 32'h0800_F000, 1'b0, 1'b1, 1'b1,
             ev(1'b1, 16'h1800, 16'h1000), ev(1'b1, 16'h0800, 16'h3000));
        repeat (2) @(posedge clk); #1;
        chk("latency_early", 33'(o0.tvalid), 33'd0);
        @(posedge clk); #1;
        chk("latency_3clk", 33'(o0.tvalid), 33'd1);
        drain();

        // saturation, MULT, clip and round-half-up
        send(32'h7FFF_8000, 32'h0001_8000, 1'b0, 1'b1, 1'b1,
             ev(1'b1, 16'h7FFF, 16'h8000), ev(1'b1, 16'h7FFE, 16'h0000));
        send(32'h4000_0000, 32'h4000_4000, 1'b1, 1'b1, 1'b1,
             ev(1'b1, 16'h2000, 16'h2000), ev(1'b1, 16'h2000, 16'hE000));
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1,
             ev(1'b1, 16'h7FFF, 16'h0000), ev(1'b1, 16'h7FFF, 16'h0000));
        send(32'h0001_0000, 32'h4000_0000, 1'b1, 1'b1, 1'b1,
             ev(1'b1, 16'h0001, 16'h0000), ev(1'b1, 16'h0001, 16'h0000));
        send(32'hFFFF_0000, 32'h4000_0000, 1'b1, 1'b1, 1'b1,
             ev(1'b1, 16'h0000, 16'h0000), ev(1'b1, 16'h0000, 16'h0000));
        drain();

        // mode toggled mid-packet stays ADDSUB until after tlast
        send(32'h0100_0200, 32'h0010_0020, 1'b0, 1'b0, 1'b0,
             ev(1'b0, 16'h0110, 16'h0220), ev(1'b0, 16'h00F0, 16'h01E0));
        send(32'h0100_0200, 32'h0010_0020, 1'b1, 1'b0, 1'b0,
             ev(1'b0, 16'h0110, 16'h0220), ev(1'b0, 16'h00F0, 16'h01E0));
        send(32'h0100_0200, 32'h0010_0020, 1'b1, 1'b1, 1'b1,
             ev(1'b1, 16'h0110, 16'h0220), ev(1'b1, 16'h00F0, 16'h01E0));
        send(32'h4000_0000, 32'h4000_4000, 1'b1, 1'b1, 1'b1,
             ev(1'b1, 16'h2000, 16'h2000), ev(1'b1, 16'h2000, 16'hE000));
        send(32'h1000_2000, 32'h0800_F000, 1'b0, 1'b1, 1'b1,
             ev(1'b1, 16'h1800, 16'h1000), ev(1'b1, 16'h0800, 16'h3000));
        drain();
        chk("tlast_err_clean", 33'(tlast_err), 33'd0);

        // tlast mismatch is sticky
        send(32'h0002_0003, 32'h0001_0001, 1'b0, 1'b0, 1'b1,
             ev(1'b0, 16'h0003, 16'h0004), ev(1'b0, 16'h0001, 16'h0002));
        chk("tlast_err_set", 33'(tlast_err), 33'd1);
        send(32'h0002_0003, 32'h0001_0001, 1'b0, 1'b1, 1'b1,
             ev(1'b1, 16'h0003, 16'h0004), ev(1'b1, 16'h0001, 16'h0002));
        drain();
        chk("tlast_err_sticky", 33'(tlast_err), 33'd1);

        // o1 blocked: o0 drains one FIFO's worth, three beats wait in the pipeline
        o1.tready = 1'b0;
        b0 = o0_cnt; b1 = o1_cnt; ba = acc_cnt;
        fork
            begin
                for (int k = 1; k <= 10; k++) begin
                    send({16'(k*256), 16'(k)}, {16'(k), 16'h0010}, 1'b0, 1'b1, 1'b1,
                         ev(1'b1, 16'(k*257), 16'(k+16)), ev(1'b1, 16'(k*255), 16'(k-16)));
                end
            end
            begin
                repeat (40) @(posedge clk); #1;
                chk("bp_o0_count", 33'(o0_cnt - b0), 33'd4);
                chk("bp_accepted", 33'(acc_cnt - ba), 33'd7);
                chk("bp_o1_waiting", 33'(o1.tvalid), 33'd1);
                o1.tready = 1'b1;
            end
        join
        drain();
        chk("bp_o0_total", 33'(o0_cnt - b0), 33'd10);
        chk("bp_o1_total", 33'(o1_cnt - b1), 33'd10);

        // reset with two beats queued and three in flight
        o0.tready = 1'b0; o1.tready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send({16'(k*256), 16'(k)}, {16'(k), 16'h0010}, 1'b0, 1'b1, 1'b1,
                 ev(1'b1, 16'(k*257), 16'(k+16)), ev(1'b1, 16'(k*255), 16'(k-16)));
        end
        chk("pre_rst_o0_tvalid", 33'(o0.tvalid), 33'd1);
        i0.tvalid = 1'b1; i1.tvalid = 1'b1;
        #2;
        reset_n = 1'b0;
        exp0.delete(); exp1.delete();
        #1;
        chk("rst_mid_o0_tvalid", 33'(o0.tvalid), 33'd0);
        chk("rst_mid_o1_tvalid", 33'(o1.tvalid), 33'd0);
        chk("rst_mid_i0_tready", 33'(i0.tready), 33'd0);
        chk("rst_mid_tlast_err", 33'(tlast_err), 33'd0);
        @(posedge clk); #1;
        i0.tvalid = 1'b0; i1.tvalid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        o0.tready = 1'b1; o1.tready = 1'b1;
        repeat (2) @(posedge clk); #1;
        b0 = o0_cnt;
        send(32'h4000_0000, 32'h4000_4000, 1'b1, 1'b1, 1'b1,
             ev(1'b1, 16'h2000, 16'h2000), ev(1'b1, 16'h2000, 16'hE000));
        drain();
        repeat (10) @(posedge clk); #1;
        chk("post_rst_o0_count", 33'(o0_cnt - b0), 33'd1);

        // SATURATE=0 instance wraps instead of clipping
        wi0.tdata = 32'h7FFF_8000; wi1.tdata = 32'h0001_8000;
        wi0.tlast = 1'b1; wi1.tlast = 1'b1;
        wi0.tvalid = 1'b1; wi1.tvalid = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 20) begin
            @(negedge clk);
            hs = wi0.tready;
            @(posedge clk);
            n++;
        end
        #1;
        wi0.tvalid = 1'b0; wi1.tvalid = 1'b0;
        chk("wrap_accept", 33'(hs), 33'd1);
        n = 0;
        while (!wo0.tvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wrap_o0", {wo0.tlast, wo0.tdata}, ev(1'b1, 16'h8000, 16'h0000));
        chk("wrap_o1", {wo1.tlast, wo1.tdata}, ev(1'b1, 16'h7FFE, 16'h0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
